// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared group codes, ALU codes and FSM state encoding
package multicycle_controller_pkg;

    // Instruction group codes carried in the command_group field; 7 is illegal
    localparam int GRP_NOP = 0;
    localparam int GRP_MOV = 1;
    localparam int GRP_JMP = 2;
    localparam int GRP_JCC = 3;
    localparam int GRP_ALU = 4;
    localparam int GRP_LD  = 5;
    localparam int GRP_ST  = 6;

    // ALU pass-through code; the unconditional-branch code is all ones at any width
    localparam int ALU_NOOP = 0;

    // Controller states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_BRANCH = 3'd4,
        S_MEM    = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    // True for any group code the decoder knows how to sequence
    function automatic logic is_legal_group(input int unsigned grp);
        return grp <= GRP_ST;
    endfunction

endpackage

// File: rtl/multicycle_controller_ctrl_wait_timer.sv
// rtl/multicycle_controller_ctrl_wait_timer.sv - memory-wait counter with timeout compare
module ctrl_wait_timer #(
    parameter int WAIT_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wait_en_i,
    input  logic ready_i,
    output logic timeout_o
);

    // The count holds the number of completed waiting cycles, so the last
    // allowed waiting cycle is the one that sees MEM_TIMEOUT-1.
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Count waiting cycles while active; any ready or leaving the wait state clears
    always_comb begin
        count_d = count_q;
        if (!wait_en_i || ready_i) begin
            count_d = '0;
        end else if (count_q < LIMIT) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Ready in the same cycle wins over the timeout
    always_comb begin
        timeout_o = wait_en_i && !ready_i && (count_q >= LIMIT);
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle instruction controller FSM (optional CTRL_STALL_COUNT_EN stall counter)
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int GROUP_W     = 3,
    parameter int ALU_OP_W    = 4,
    parameter int WAIT_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                instr_valid,
    input  logic [GROUP_W-1:0]  command_group,
    input  logic [ALU_OP_W-1:0] alu_func,
    input  logic                cond_flag,
    input  logic                mem_ready,
    output logic                fetch_req,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                write_enable,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                branch_select,
    output logic                branch_taken,
    output logic                mem_req,
    output logic                mem_we,
    output logic                busy,
`ifdef CTRL_STALL_COUNT_EN
    output logic [15:0]         stall_count,
`endif
    output logic                fault
);

    localparam logic [GROUP_W-1:0]  G_NOP = GROUP_W'(GRP_NOP);
    localparam logic [GROUP_W-1:0]  G_MOV = GROUP_W'(GRP_MOV);
    localparam logic [GROUP_W-1:0]  G_JMP = GROUP_W'(GRP_JMP);
    localparam logic [GROUP_W-1:0]  G_JCC = GROUP_W'(GRP_JCC);
    localparam logic [GROUP_W-1:0]  G_ALU = GROUP_W'(GRP_ALU);
    localparam logic [GROUP_W-1:0]  G_LD  = GROUP_W'(GRP_LD);
    localparam logic [GROUP_W-1:0]  G_ST  = GROUP_W'(GRP_ST);
    localparam logic [ALU_OP_W-1:0] A_NOOP  = ALU_OP_W'(ALU_NOOP);
    localparam logic [ALU_OP_W-1:0] A_UNCOP = '1;

    state_e              state_q;
    state_e              state_d;
    logic [GROUP_W-1:0]  group_q;
    logic [GROUP_W-1:0]  group_d;
    logic [ALU_OP_W-1:0] func_q;
    logic [ALU_OP_W-1:0] func_d;
    logic                mem_timeout;

    ctrl_wait_timer #(
        .WAIT_W      (WAIT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .wait_en_i (state_q == S_MEM),
        .ready_i   (mem_ready),
        .timeout_o (mem_timeout)
    );

    // Next-state selection and instruction field capture on ir_load
    always_comb begin
        state_d = state_q;
        group_d = group_q;
        func_d  = func_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    state_d = S_DECODE;
                    group_d = command_group;
                    func_d  = alu_func;
                end
            end
            S_DECODE: begin
                if (!is_legal_group(32'(group_q))) begin
                    state_d = S_FAULT;
                end else begin
                    case (group_q)
                        G_NOP:        state_d = S_FETCH;
                        G_MOV, G_ALU: state_d = S_EXEC;
                        G_JMP, G_JCC: state_d = S_BRANCH;
                        G_LD, G_ST:   state_d = S_MEM;
                        default:      state_d = S_FAULT;
                    endcase
                end
            end
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (group_q == G_LD) ? S_WB : S_FETCH;
                end else if (mem_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    // State and latched instruction fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            group_q <= G_NOP;
            func_q  <= '0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
            func_q  <= func_d;
        end
    end

    // Output decode from state and latched group; ir_load is the only term
    // that looks at instr_valid directly
    always_comb begin
        fetch_req     = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        write_enable  = 1'b0;
        alu_op        = A_NOOP;
        branch_select = 1'b0;
        branch_taken  = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        busy          = (state_q != S_FETCH);
        fault         = (state_q == S_FAULT);
        case (state_q)
            S_FETCH: begin
                fetch_req = 1'b1;
                ir_load   = instr_valid;
            end
            S_DECODE: begin
                pc_inc = (group_q == G_NOP);
            end
            S_EXEC: begin
                alu_op = (group_q == G_ALU) ? func_q : A_NOOP;
            end
            S_WB: begin
                write_enable = 1'b1;
                pc_inc       = 1'b1;
                alu_op       = (group_q == G_ALU) ? func_q : A_NOOP;
            end
            S_BRANCH: begin
                branch_select = 1'b1;
                if (group_q == G_JMP) begin
                    alu_op       = A_UNCOP;
                    branch_taken = 1'b1;
                end else begin
                    alu_op       = func_q;
                    branch_taken = cond_flag;
                end
                pc_inc = !branch_taken;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (group_q == G_ST);
                pc_inc  = mem_ready && (group_q == G_ST);
            end
            default: begin
            end
        endcase
    end

`ifdef CTRL_STALL_COUNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles spent waiting on instruction or data memory
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (((state_q == S_FETCH) && !instr_valid) ||
                     ((state_q == S_MEM) && !mem_ready)) begin
            if (stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       instr_valid;
    logic [2:0] command_group;
    logic [3:0] alu_func;
    logic       cond_flag;
    logic       mem_ready;
    logic       fetch_req;
    logic       ir_load;
    logic       pc_inc;
    logic       write_enable;
    logic [3:0] alu_op;
    logic       branch_select;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_we;
    logic       busy;
    logic       fault;
`ifdef CTRL_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(
        .GROUP_W     (3),
        .ALU_OP_W    (4),
        .WAIT_W      (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_valid   (instr_valid),
        .command_group (command_group),
        .alu_func      (alu_func),
        .cond_flag     (cond_flag),
        .mem_ready     (mem_ready),
        .fetch_req     (fetch_req),
        .ir_load       (ir_load),
        .pc_inc        (pc_inc),
        .write_enable  (write_enable),
        .alu_op        (alu_op),
        .branch_select (branch_select),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .busy          (busy),
`ifdef CTRL_STALL_COUNT_EN
        .stall_count   (stall_count),
`endif
        .fault         (fault)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        string name;
        int grp, func, cond, waits;
        int lat, we_cyc, pc_cyc, taken, bsel, alu, memreq, memwe;
    } vec_t;

    typedef struct {
        string name;
        int lat, we_cyc, pc_cyc, taken, bsel, alu, memreq, memwe;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic do_reset();
        reset_n = 1'b0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        cond_flag = 1'b0;
        command_group = '0;
        alu_func = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drive one instruction from S_FETCH and observe it until fetch_req returns
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int cyc = 0, memcyc = 0, excl = 0, irl = 0, done = 0;
        e.name = v.name; e.lat = v.lat; e.we_cyc = v.we_cyc; e.pc_cyc = v.pc_cyc;
        e.taken = v.taken; e.bsel = v.bsel; e.alu = v.alu; e.memreq = v.memreq; e.memwe = v.memwe;
        sb.push_back(e);
        got = '{name: v.name, lat: 0, we_cyc: 0, pc_cyc: 0, taken: 0, bsel: 0, alu: 0, memreq: 0, memwe: 0};
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                instr_valid = 1'b1;
                command_group = v.grp[2:0];
                alu_func = v.func[3:0];
                cond_flag = v.cond[0];
            end else begin
                instr_valid = 1'b0;
            end
            if (mem_req) begin
                memcyc++;
                mem_ready = (memcyc > v.waits);
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (cyc > 1 && fetch_req) begin
                done = 1;
                got.lat = cyc - 1;
            end else begin
                if (cyc == 1) irl = int'(ir_load);
                if (write_enable) got.we_cyc = cyc;
                if (pc_inc) got.pc_cyc = cyc;
                if (branch_taken) got.taken++;
                if (branch_select) got.bsel++;
                if (write_enable || branch_select) got.alu = int'(alu_op);
                if (mem_req) got.memreq++;
                if (mem_req && mem_we) got.memwe++;
                if ((int'(write_enable) + int'(mem_req) + int'(branch_taken)) > 1 ||
                    (pc_inc && branch_taken)) excl++;
            end
        end
        mem_ready = 1'b0;
        cond_flag = 1'b0;
        check({v.name, " completes"}, done, 1);
        check({v.name, " ir_load cycle1"}, irl, 1);
        check({v.name, " exclusion"}, excl, 0);
        if (sb.size() == 0) begin
            check({v.name, " scoreboard entry"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({e.name, " latency"}, got.lat, e.lat);
            check({e.name, " write_enable cycle"}, got.we_cyc, e.we_cyc);
            check({e.name, " pc_inc cycle"}, got.pc_cyc, e.pc_cyc);
            check({e.name, " branch_taken cycles"}, got.taken, e.taken);
            check({e.name, " branch_select cycles"}, got.bsel, e.bsel);
            check({e.name, " alu_op"}, got.alu, e.alu);
            check({e.name, " mem_req cycles"}, got.memreq, e.memreq);
            check({e.name, " mem_we cycles"}, got.memwe, e.memwe);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, memcnt, bad, we_seen, fault_cyc;

        //             name       grp func cond wt lat we pc tk bs alu mr mw
        vecs.push_back('{"NOP",    0, 0,  0, 0, 2, 0, 2, 0, 0, 0,  0, 0});
        vecs.push_back('{"MOV",    1, 5,  0, 0, 4, 4, 4, 0, 0, 0,  0, 0});
        vecs.push_back('{"ALU",    4, 9,  0, 0, 4, 4, 4, 0, 0, 9,  0, 0});
        vecs.push_back('{"JMP",    2, 3,  0, 0, 3, 0, 0, 1, 1, 15, 0, 0});
        vecs.push_back('{"JCC_nt", 3, 3,  0, 0, 3, 0, 3, 0, 1, 3,  0, 0});
        vecs.push_back('{"JCC_t",  3, 3,  1, 0, 3, 0, 0, 1, 1, 3,  0, 0});
        vecs.push_back('{"LD_w0",  5, 7,  0, 0, 4, 4, 4, 0, 0, 0,  1, 0});
        vecs.push_back('{"LD_w3",  5, 0,  0, 3, 7, 7, 7, 0, 0, 0,  4, 0});
        vecs.push_back('{"ST_w0",  6, 0,  0, 0, 3, 0, 3, 0, 0, 0,  1, 1});
        vecs.push_back('{"ST_w2",  6, 0,  0, 2, 5, 0, 5, 0, 0, 0,  3, 3});

        // Reset state, sampled while reset is held
        reset_n = 1'b0;
        instr_valid = 1'b0; mem_ready = 1'b0; cond_flag = 1'b0;
        command_group = '0; alu_func = '0;
        #3;
        check("reset fetch_req", int'(fetch_req), 1);
        check("reset ir_load", int'(ir_load), 0);
        check("reset busy", int'(busy), 0);
        check("reset fault", int'(fault), 0);
        check("reset alu_op", int'(alu_op), 0);
        check("reset strobes", int'({pc_inc, write_enable, mem_req, mem_we, branch_taken, branch_select}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Store with mem_ready held low runs into the timeout
        @(posedge clk); #1;
        instr_valid = 1'b1; command_group = 3'd6; mem_ready = 1'b0;
        cyc = 0; memcnt = 0; fault_cyc = 0;
        while (fault_cyc == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req) memcnt++;
            if (fault) fault_cyc = cyc;
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
        check("ST timeout mem_req cycles", memcnt, 15);
        check("ST timeout fault cycle", fault_cyc, 18);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!fault || !busy || fetch_req || ir_load || pc_inc || write_enable ||
                mem_req || mem_we || branch_taken || branch_select) bad++;
            @(posedge clk); #1;
            instr_valid = 1'b1;
            mem_ready = 1'b1;
        end
        check("fault sticky no strobes", bad, 0);
        do_reset();

        // Illegal group code faults right after decode; reset clears asynchronously
        @(posedge clk); #1;
        instr_valid = 1'b1; command_group = 3'd7;
        cyc = 0; fault_cyc = 0;
        while (fault_cyc == 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (fault) fault_cyc = cyc;
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
        check("illegal group fault cycle", fault_cyc, 3);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("async reset fault", int'(fault), 0);
        check("async reset fetch_req", int'(fetch_req), 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset during the memory wait of a load
        @(posedge clk); #1;
        instr_valid = 1'b1; command_group = 3'd5; mem_ready = 1'b0;
        cyc = 0; memcnt = 0; we_seen = 0;
        while (memcnt < 2 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_req) memcnt++;
            if (write_enable) we_seen++;
            if (memcnt < 2) begin
                @(posedge clk); #1;
                instr_valid = 1'b0;
            end
        end
        check("LD reached mem wait", memcnt, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset mid-LD mem_req", int'(mem_req), 0);
        check("reset mid-LD fetch_req", int'(fetch_req), 1);
        instr_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (write_enable) we_seen++;
        end
        reset_n = 1'b1;
        check("reset mid-LD no write_enable", we_seen, 0);
        run_vec(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequential successor to the single-cycle combinational command decoder.
- Drives a multi-cycle FSM per instruction: FETCH, DECODE, EXECUTE/BRANCH/MEMORY, WRITEBACK.
- Generalised in opcode width, ALU op width and memory-wait timeout. Adds conditional branch, load/store with a ready handshake, and a sticky fault.
- Sits between the instruction register/PC and the datapath (ALU, register file, data memory).

Parameters:
- GROUP_W, 3: command_group width.
- ALU_OP_W, 4: alu_op / alu_func width.
- WAIT_W, 4: width of the memory-wait counter.
- MEM_TIMEOUT, 15: maximum S_MEM cycles without mem_ready before fault; must be ≤ 2^WAIT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction memory data valid.
- command_group  input  GROUP_W  group field of the current instruction word.
- alu_func  input  ALU_OP_W  function field for ALU/JCC groups.
- cond_flag  input  1  branch condition from ALU.
- mem_ready  input  1  data memory access complete.
- fetch_req  output  1  request instruction fetch.
- ir_load  output  1  load instruction register.
- pc_inc  output  1  increment PC this cycle.
- write_enable  output  1  register file write.
- alu_op  output  ALU_OP_W  ALU operation.
- branch_select  output  1  PC source = branch target when branch_taken.
- branch_taken  output  1  load PC from target this cycle.
- mem_req  output  1  data memory request.
- mem_we  output  1  data memory write (valid with mem_req).
- busy  output  1  high in every state except S_FETCH.
- fault  output  1  sticky fault indication.

Behaviour:
- Reset (async, reset_n=0):
  - state=S_FETCH, latched group=`NOP, wait counter=0.
  - All outputs 0 except fetch_req=1 (Moore decode of S_FETCH); alu_op=`NOOP.
- Group latch: command_group and alu_func are latched on ir_load. Later states use only the latched copies.
- Output decode: all outputs are Moore, decoded from state plus the latched group. ir_load = (state==S_FETCH) & instr_valid is the only Mealy term.
- S_FETCH:
  - fetch_req=1.
  - Stays while instr_valid=0.
  - On instr_valid=1, ir_load=1, then → S_DECODE.
- S_DECODE (1 cycle):
  - `NOP → S_FETCH with pc_inc=1.
  - `MOV, `ALU → S_EXEC.
  - `JMP, `JCC → S_BRANCH.
  - `LD, `ST → S_MEM.
  - Any other code → S_FAULT.
- S_EXEC (1 cycle):
  - alu_op=`NOOP for MOV; alu_op=latched alu_func for ALU.
  - → S_WB.
- S_WB (1 cycle): write_enable=1, pc_inc=1, alu_op held from S_EXEC, → S_FETCH.
- S_BRANCH (1 cycle):
  - branch_select=1.
  - JMP: alu_op=`UNCOP, branch_taken=1.
  - JCC: alu_op=latched alu_func, branch_taken=cond_flag.
  - pc_inc = ~branch_taken.
  - → S_FETCH.
- S_MEM:
  - mem_req=1 held; mem_we=1 for ST only.
  - Wait counter increments each cycle mem_ready=0.
  - mem_ready=1: clear counter. LD → S_WB. ST → S_FETCH with pc_inc=1.
  - Counter reaches MEM_TIMEOUT with mem_ready=0 → S_FAULT. mem_ready takes priority in the same cycle.
- S_FAULT:
  - fault=1, all strobes 0, fetch_req=0.
  - Absorbing; only reset_n exits.
- Latency (cycles, zero wait): NOP 2; MOV/ALU 4; JMP/JCC 3; ST 3; LD 4. Add 1 per memory wait cycle.
- Reset mid-instruction: immediate return to S_FETCH. No partial write_enable or mem_req survives.
- Mutual exclusion: write_enable, mem_req and branch_taken are never high together. pc_inc and branch_taken are never both high.

Optional Feature:
- Macro: CTRL_STALL_COUNT_EN.
- With the macro defined:
  - Adds output stall_count [15:0].
  - Increments (saturating at 16'hFFFF) every cycle spent in S_FETCH with instr_valid=0, or in S_MEM with mem_ready=0.
  - Reset to 0.
- Without the macro: port and counter are absent. All other behaviour is identical.

Decomposition:
- cpu_definitions.vh holds:
  - group codes: `NOP=0, `MOV=1, `JMP=2, `JCC=3, `ALU=4, `LD=5, `ST=6; 7 is illegal.
  - ALU codes `NOOP and `UNCOP.
  - state encodings S_FETCH..S_FAULT.
- One sub-module, ctrl_wait_timer: wait counter plus timeout compare, parameterised by WAIT_W and MEM_TIMEOUT.

Test Plan:
- MOV, instr_valid=1 at cycle 1 → ir_load cycle 1; write_enable=1 and pc_inc=1 in cycle 4; fetch_req returns in cycle 5.
- JCC with alu_func=4'h3, cond_flag=0, then repeated with cond_flag=1 → case 1: branch_taken=0, pc_inc=1; case 2: branch_taken=1, pc_inc=0; both have branch_select=1 and alu_op=4'h3.
- LD with mem_ready after 3 low cycles → mem_req high for 4 cycles, then write_enable=1 in the next cycle. Stall_count=3 if enabled.
- ST with mem_ready held low, MEM_TIMEOUT=15 → fault=1 after 15 S_MEM cycles; fault stays high 50 more cycles; no strobes asserted.
- command_group=7 → fault=1 in the cycle after decode. reset_n pulse low → fault=0, fetch_req=1 asynchronously.
- reset_n asserted during S_MEM of an LD → mem_req drops immediately; write_enable is never asserted; fetch restarts after release.
